lsu_ctrl: RTL and testbench

Parametrised load/store unit; next generation of the combinational memory-op controller.
- Accepts one load/store per request from the execute stage and runs a req/ack handshake to data memory.
- Generates byte enables and lane-aligned write data for sub-word stores.
- Extracts and sign/zero-extends sub-word loads from any legal byte offset.
- Reports misalignment and bus-timeout errors.

---
 rtl/lsu_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store unit: req/ack memory handshake, sub-word byte enables, lane replication and load extension.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_ctrl #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        lsu_valid,
  input  logic [3:0]                                  lsu_op,
  input  logic [ADDR_WIDTH-1:0]                       lsu_addr,
  input  logic [WORD_WIDTH-1:0]                       lsu_wdata,
  output logic                                        lsu_ready,
  output logic                                        lsu_done,
  output logic [WORD_WIDTH-1:0]                       lsu_rdata,
  output logic [1:0]                                  lsu_err,
  output logic                                        mem_req,
  output logic                                        mem_we,
  output logic [ADDR_WIDTH-$clog2(WORD_WIDTH/8)-1:0]  mem_addr,
  output logic [WORD_WIDTH/8-1:0]                     mem_be,
  output logic [WORD_WIDTH-1:0]                       mem_wdata,
  input  logic                                        mem_ack,
  input  logic [WORD_WIDTH-1:0]                       mem_rdata
);

  localparam int unsigned BYTES   = WORD_WIDTH / 8;
  localparam int unsigned OFF_W   = $clog2(BYTES);
  localparam int unsigned MADDR_W = ADDR_WIDTH - OFF_W;
  localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  state_e                  state_q, state_d;
  logic                    ready_q, ready_d, done_q, done_d, req_q, req_d, we_q, we_d;
  logic [WORD_WIDTH-1:0]   rdata_q, rdata_d, wdata_q, wdata_d;
  logic [1:0]              err_q, err_d;
  logic [MADDR_W-1:0]      maddr_q, maddr_d;
  logic [BYTES-1:0]        be_q, be_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [OFF_W-1:0]        off_q, off_d;
  logic [2:0]              nbytes_q, nbytes_d;
  logic                    signed_q, signed_d;

  // Op decode: access size in bytes, sign extension, legality
  logic       op_ok, op_signed;
  logic [2:0] op_nbytes;
  always_comb begin
    op_ok     = 1'b1;
    op_signed = 1'b0;
    op_nbytes = 3'd1;
    case (lsu_op)
      4'b0001: begin op_nbytes = 3'd1; op_signed = 1'b1; end
      4'b0010: begin op_nbytes = 3'd2; op_signed = 1'b1; end
      4'b0011: begin op_nbytes = 3'd4; op_signed = 1'b1; end
      4'b0100: op_nbytes = 3'd1;
      4'b0101: op_nbytes = 3'd2;
      4'b1001: op_nbytes = 3'd1;
      4'b1010: op_nbytes = 3'd2;
      4'b1011: op_nbytes = 3'd4;
      default: op_ok = 1'b0;
    endcase
  end

  // Request-side lane formatting: aligned offset, byte enables, replicated store data
  logic [OFF_W-1:0]      size_mask, raw_off, aln_off;
  logic [3:0]            be_pat;
  logic [BYTES-1:0]      be_new;
  logic [WORD_WIDTH-1:0] wdata_rep;
  logic [1:0]            lane;
  always_comb begin
    size_mask = OFF_W'(op_nbytes - 3'd1);
    raw_off   = lsu_addr[OFF_W-1:0];
    aln_off   = raw_off & ~size_mask;
    be_pat    = (op_nbytes == 3'd4) ? 4'b1111 : (op_nbytes == 3'd2) ? 4'b0011 : 4'b0001;
    be_new    = BYTES'(be_pat) << aln_off;
    wdata_rep = '0;
    lane      = 2'd0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      lane = 2'(i) & 2'(op_nbytes - 3'd1);
      wdata_rep[8*i +: 8] = lsu_wdata[{lane, 3'b000} +: 8];
    end
  end

  // Load-side extraction and extension from the latched offset
  logic [WORD_WIDTH-1:0] shifted, load_ext;
  logic                  sbit;
  always_comb begin
    shifted  = mem_rdata >> {off_q, 3'b000};
    load_ext = '0;
    sbit     = 1'b0;
    case (nbytes_q)
      3'd1: begin
        sbit     = signed_q & shifted[7];
        load_ext = {{(WORD_WIDTH-8){sbit}}, shifted[7:0]};
      end
      3'd2: begin
        sbit     = signed_q & shifted[15];
        load_ext = {{(WORD_WIDTH-16){sbit}}, shifted[15:0]};
      end
      default: begin
        sbit     = signed_q & shifted[31];
        load_ext = {{(WORD_WIDTH-32){sbit}}, shifted[31:0]};
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    we_d     = we_q;
    maddr_d  = maddr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    off_d    = off_q;
    nbytes_d = nbytes_q;
    signed_d = signed_q;
    case (state_q)
      IDLE: begin
        if (lsu_valid && op_ok) begin
          we_d     = lsu_op[3];
          maddr_d  = lsu_addr[ADDR_WIDTH-1:OFF_W];
          be_d     = be_new;
          wdata_d  = wdata_rep;
          off_d    = aln_off;
          nbytes_d = op_nbytes;
          signed_d = op_signed;
          rdata_d  = '0;
          err_d    = 2'b00;
          cnt_d    = '0;
          state_d  = REQ;
`ifdef LSU_MISALIGN_TRAP_EN
          if ((raw_off & size_mask) != '0) begin
            err_d   = 2'b01;
            state_d = DONE;
          end
`endif
        end
      end
      REQ: begin
        if (mem_ack) begin
          rdata_d = we_q ? '0 : load_ext;
          err_d   = 2'b00;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 2'b10;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
    req_d   = (state_d == REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
      wdata_q  <= '0;
      err_q    <= 2'b00;
      maddr_q  <= '0;
      be_q     <= '0;
      cnt_q    <= '0;
      off_q    <= '0;
      nbytes_q <= 3'd1;
      signed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      req_q    <= req_d;
      we_q     <= we_d;
      rdata_q  <= rdata_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      maddr_q  <= maddr_d;
      be_q     <= be_d;
      cnt_q    <= cnt_d;
      off_q    <= off_d;
      nbytes_q <= nbytes_d;
      signed_q <= signed_d;
    end
  end

  assign lsu_ready = ready_q;
  assign lsu_done  = done_q;
  assign lsu_rdata = rdata_q;
  assign lsu_err   = err_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = maddr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: scoreboard of expected {rdata, err} per access plus bus-side checks.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst, lsu_valid, lsu_ready, lsu_done, mem_req, mem_we, mem_ack;
  logic [3:0]  lsu_op, mem_be;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata, mem_wdata, mem_rdata;
  logic [1:0]  lsu_err;
  logic [29:0] mem_addr;

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk(clk), .rst(rst), .lsu_valid(lsu_valid), .lsu_op(lsu_op), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_ready(lsu_ready), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
    .lsu_err(lsu_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct packed { logic [31:0] rdata; logic [1:0] err; } res_t;
  res_t exp_q[$];
  res_t got_q[$];
  res_t e, g;

  int total = 0;
  int bad   = 0;

  int          req_cycles, done_cycle, extra_done;
  logic        unstable, obs_we;
  logic [3:0]  obs_be;
  logic [29:0] obs_addr;
  logic [31:0] obs_wd;

  // Issue one request, play memory with ack in REQ cycle ack_at (0 = never), record bus view and result
  task automatic drive_access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rsp, input int ack_at);
    res_t r;
    logic first;
    for (int w = 0; w < 20 && lsu_ready !== 1'b1; w++) begin @(posedge clk); #1; end
    lsu_valid = 1'b1; lsu_op = op; lsu_addr = addr; lsu_wdata = wdata;
    @(posedge clk); #1;
    lsu_valid = 1'b0; lsu_op = 4'b0000;
    req_cycles = 0; done_cycle = 0; unstable = 1'b0; first = 1'b1;
    obs_be = 'x; obs_addr = 'x; obs_wd = 'x; obs_we = 1'bx;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (mem_req === 1'b1) begin
        if (first) begin
          obs_be = mem_be; obs_addr = mem_addr; obs_wd = mem_wdata; obs_we = mem_we; first = 1'b0;
        end else if (mem_be !== obs_be || mem_addr !== obs_addr || mem_wdata !== obs_wd || mem_we !== obs_we) begin
          unstable = 1'b1;
        end
        req_cycles++;
        if (cyc == ack_at) begin mem_ack = 1'b1; mem_rdata = rsp; end
      end
      if (lsu_done === 1'b1) begin
        done_cycle = cyc; r.rdata = lsu_rdata; r.err = lsu_err; got_q.push_back(r);
      end
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = 32'h5A5A_C3C3;
      if (done_cycle != 0) break;
    end
    extra_done = int'(lsu_done);
  endtask

  task automatic test_reset;
    rst = 1'b1; lsu_valid = 1'b0; lsu_op = '0; lsu_addr = '0; lsu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({lsu_ready, lsu_done, lsu_err, mem_req, mem_we, mem_be} !== {1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000}) begin
      bad++; $display("FAIL reset_ctrl: got %b want 1000000000", {lsu_ready, lsu_done, lsu_err, mem_req, mem_we, mem_be});
    end
    total++;
    if ({lsu_rdata, mem_wdata, mem_addr} !== '0) begin
      bad++; $display("FAIL reset_data: rdata=%h wdata=%h addr=%h want all 0", lsu_rdata, mem_wdata, mem_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_store_word;
    exp_q.push_back('{32'h0, 2'b00});
    drive_access(4'b1011, 32'h100, 32'hDEADBEEF, 32'h0, 3);
    total++;
    if ({obs_addr, obs_be, obs_we} !== {30'h40, 4'b1111, 1'b1}) begin
      bad++; $display("FAIL sw_bus: addr=%h be=%b we=%b want 40 1111 1", obs_addr, obs_be, obs_we);
    end
    total++;
    if (obs_wd !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_wdata: got %h want deadbeef", obs_wd); end
    total++;
    if (req_cycles != 3 || unstable) begin
      bad++; $display("FAIL sw_req_hold: cycles=%0d unstable=%b want 3 0", req_cycles, unstable);
    end
    total++;
    if (done_cycle != 4 || extra_done != 0) begin
      bad++; $display("FAIL sw_done_pulse: cycle=%0d extra=%0d want 4 0", done_cycle, extra_done);
    end
    total++;
    if (got_q.size() == 0) begin bad++; $display("FAIL sw_result: no lsu_done seen"); void'(exp_q.pop_front()); end
    else begin e = exp_q.pop_front(); g = got_q.pop_front();
      if (g !== e) begin bad++; $display("FAIL sw_result: got %h/%b want %h/%b", g.rdata, g.err, e.rdata, e.err); end
    end
  endtask

  task automatic test_store_byte;
    exp_q.push_back('{32'h0, 2'b00});
    drive_access(4'b1001, 32'h103, 32'h000000A5, 32'h0, 1);
    total++;
    if ({obs_be, obs_wd} !== {4'b1000, 32'hA5A5A5A5}) begin
      bad++; $display("FAIL sb_lane: be=%b wdata=%h want 1000 a5a5a5a5", obs_be, obs_wd);
    end
    total++;
    if (done_cycle != 2) begin bad++; $display("FAIL sb_latency: done cycle=%0d want 2", done_cycle); end
    total++;
    if (got_q.size() == 0) begin bad++; $display("FAIL sb_result: no lsu_done seen"); void'(exp_q.pop_front()); end
    else begin e = exp_q.pop_front(); g = got_q.pop_front();
      if (g !== e) begin bad++; $display("FAIL sb_result: got %h/%b want %h/%b", g.rdata, g.err, e.rdata, e.err); end
    end
  endtask

  task automatic test_loads;
    logic [3:0]  ops   [4] = '{4'b0001, 4'b0100, 4'b0010, 4'b0101};
    logic [31:0] addrs [4] = '{32'h203, 32'h203, 32'h202, 32'h200};
    logic [31:0] vals  [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80F0, 32'h00007F01};
    logic [3:0]  bes   [4] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{vals[i], 2'b00});
      drive_access(ops[i], addrs[i], 32'h0, 32'h80F07F01, 1);
      total++;
      if ({obs_be, obs_we, obs_addr} !== {bes[i], 1'b0, 30'h80}) begin
        bad++; $display("FAIL load%0d_bus: be=%b we=%b addr=%h want %b 0 80", i, obs_be, obs_we, obs_addr, bes[i]);
      end
      total++;
      if (got_q.size() == 0) begin bad++; $display("FAIL load%0d_result: no lsu_done seen", i); void'(exp_q.pop_front()); end
      else begin e = exp_q.pop_front(); g = got_q.pop_front();
        if (g !== e) begin bad++; $display("FAIL load%0d_result: got %h/%b want %h/%b", i, g.rdata, g.err, e.rdata, e.err); end
      end
    end
  endtask

  task automatic test_timeout;
    exp_q.push_back('{32'h0, 2'b10});
    drive_access(4'b0011, 32'h300, 32'h0, 32'h0, 0);
    total++;
    if (req_cycles != 15 || done_cycle != 16) begin
      bad++; $display("FAIL timeout_len: req=%0d done=%0d want 15 16", req_cycles, done_cycle);
    end
    total++;
    if (got_q.size() == 0) begin bad++; $display("FAIL timeout_result: no lsu_done seen"); void'(exp_q.pop_front()); end
    else begin e = exp_q.pop_front(); g = got_q.pop_front();
      if (g !== e) begin bad++; $display("FAIL timeout_result: got %h/%b want %h/%b", g.rdata, g.err, e.rdata, e.err); end
    end
    exp_q.push_back('{32'h12345678, 2'b00});
    drive_access(4'b0011, 32'h300, 32'h0, 32'h12345678, 15);
    total++;
    if (req_cycles != 15 || done_cycle != 16) begin
      bad++; $display("FAIL ack_at_limit_len: req=%0d done=%0d want 15 16", req_cycles, done_cycle);
    end
    total++;
    if (got_q.size() == 0) begin bad++; $display("FAIL ack_at_limit: no lsu_done seen"); void'(exp_q.pop_front()); end
    else begin e = exp_q.pop_front(); g = got_q.pop_front();
      if (g !== e) begin bad++; $display("FAIL ack_at_limit: got %h/%b want %h/%b", g.rdata, g.err, e.rdata, e.err); end
    end
  endtask

  task automatic test_misaligned;
`ifdef LSU_MISALIGN_TRAP_EN
    exp_q.push_back('{32'h0, 2'b01});
    drive_access(4'b0011, 32'h102, 32'h0, 32'hCAFEF00D, 1);
    total++;
    if (req_cycles != 0 || done_cycle == 0) begin
      bad++; $display("FAIL misalign_trap: req=%0d done=%0d want 0 nonzero", req_cycles, done_cycle);
    end
`else
    exp_q.push_back('{32'hCAFEF00D, 2'b00});
    drive_access(4'b0011, 32'h102, 32'h0, 32'hCAFEF00D, 1);
    total++;
    if ({obs_be, obs_addr} !== {4'b1111, 30'h40}) begin
      bad++; $display("FAIL misalign_mask: be=%b addr=%h want 1111 40", obs_be, obs_addr);
    end
`endif
    total++;
    if (got_q.size() == 0) begin bad++; $display("FAIL misalign_result: no lsu_done seen"); void'(exp_q.pop_front()); end
    else begin e = exp_q.pop_front(); g = got_q.pop_front();
      if (g !== e) begin bad++; $display("FAIL misalign_result: got %h/%b want %h/%b", g.rdata, g.err, e.rdata, e.err); end
    end
  endtask

  task automatic test_reset_mid_op;
    int seen_done = 0;
    lsu_valid = 1'b1; lsu_op = 4'b0011; lsu_addr = 32'h400;
    @(posedge clk); #1;
    lsu_valid = 1'b0; lsu_op = 4'b0000;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({mem_req, lsu_ready, lsu_done} !== 3'b010) begin
      bad++; $display("FAIL rst_mid_op: req/ready/done=%b want 010", {mem_req, lsu_ready, lsu_done});
    end
    for (int i = 0; i < 20; i++) begin
      if (lsu_done === 1'b1 || mem_req === 1'b1) seen_done++;
      @(posedge clk); #1;
    end
    total++;
    if (seen_done != 0) begin bad++; $display("FAIL rst_no_activity: active cycles=%0d want 0", seen_done); end
  endtask

  task automatic test_none_op;
    logic [3:0] codes [3] = '{4'b0000, 4'b0110, 4'b1111};
    int active = 0;
    for (int i = 0; i < 3; i++) begin
      lsu_valid = 1'b1; lsu_op = codes[i]; lsu_addr = 32'h500;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        if (mem_req !== 1'b0 || lsu_done !== 1'b0 || lsu_ready !== 1'b1) active++;
      end
    end
    lsu_valid = 1'b0; lsu_op = 4'b0000;
    total++;
    if (active != 0) begin bad++; $display("FAIL none_op: active cycles=%0d want 0", active); end
  endtask

  task automatic test_back_to_back;
    logic [3:0]  opl [8] = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b1001, 4'b1010, 4'b1011};
    logic [3:0]  op, ebe;
    logic [31:0] addr, wd, rsp, sh, ew, er;
    int          sz, off, bad_bus = 0;
    for (int n = 0; n < 16; n++) begin
      op  = opl[$urandom_range(0, 7)];
      sz  = (op[1:0] == 2'b11) ? 4 : (op == 4'b0010 || op == 4'b0101 || op == 4'b1010) ? 2 : 1;
      off = $urandom_range(0, 3) & ~(sz - 1);
      addr = {$urandom_range(0, 32'hFFFF), 16'h0} | 32'(off);
      wd = $urandom; rsp = $urandom;
      sh = rsp >> (8 * off);
      case (sz)
        1: begin ebe = 4'b0001 << off; ew = {4{wd[7:0]}};
             er = op[2] ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]}; end
        2: begin ebe = 4'b0011 << off; ew = {2{wd[15:0]}};
             er = op[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]}; end
        default: begin ebe = 4'b1111; ew = wd; er = sh; end
      endcase
      if (op[3]) er = 32'h0;
      exp_q.push_back('{er, 2'b00});
      drive_access(op, addr, wd, rsp, $urandom_range(1, 4));
      if (obs_be !== ebe || obs_addr !== addr[31:2] || obs_we !== op[3] || (op[3] && obs_wd !== ew)) bad_bus++;
      total++;
      if (got_q.size() == 0) begin bad++; $display("FAIL b2b%0d_result: no lsu_done seen", n); void'(exp_q.pop_front()); end
      else begin e = exp_q.pop_front(); g = got_q.pop_front();
        if (g !== e) begin bad++; $display("FAIL b2b%0d_result: op=%b got %h/%b want %h/%b", n, op, g.rdata, g.err, e.rdata, e.err); end
      end
    end
    total++;
    if (bad_bus != 0) begin bad++; $display("FAIL b2b_bus: %0d accesses with wrong be/addr/we/wdata, want 0", bad_bus); end
  endtask

  initial begin
    test_reset;
    test_store_word;
    test_store_byte;
    test_loads;
    test_timeout;
    test_misaligned;
    test_reset_mid_op;
    test_none_op;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
